// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, opcodes, mux select codes and the control-vector bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       sign_or_zero;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    ir_write:     1'b0,
    pc_write:     1'b0,
    iord:         1'b0,
    pc_src:       PC_INC,
    reg_dst:      RD_RT,
    mem_to_reg:   M2R_ALU,
    alu_op:       2'b00,
    alu_src:      1'b0,
    mem_read:     1'b0,
    mem_write:    1'b0,
    reg_write:    1'b0,
    sign_or_zero: 1'b1
  };

  // Per-instruction fields decoded from the latched opcode
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       sign_or_zero;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       is_beq;
    logic       is_lw;
    logic       is_sw;
    logic       is_wb;
  } dec_t;

endpackage

// File: rtl/mc_control_if.sv
// Control-unit <-> datapath bundle. The control unit uses the master
// modport; the datapath (or a bench standing in for it) uses slave.
interface mc_control_if #(parameter int OPCODE_W = 3);

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                ir_write;
  logic                pc_write;
  logic                iord;
  logic [1:0]          pc_src;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic [1:0]          alu_op;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic                sign_or_zero;
  logic                illegal;
  logic                bus_err;
  logic [2:0]          state;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, iord, pc_src, reg_dst, mem_to_reg, alu_op,
           alu_src, mem_read, mem_write, reg_write, sign_or_zero,
           illegal, bus_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, iord, pc_src, reg_dst, mem_to_reg, alu_op,
           alu_src, mem_read, mem_write, reg_write, sign_or_zero,
           illegal, bus_err, state
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational decode of the latched opcode into the ALU / writeback
// field bundle used by the EXEC, MEM and WB states.
module mc_decode
  import mc_pkg::*;
(
  input  logic [2:0] op,
  output dec_t       dec
);

  // Opcode to field bundle; j/jal never reach EXEC so they keep defaults
  always_comb begin
    dec = '{alu_op: 2'b00, alu_src: 1'b0, sign_or_zero: 1'b1,
            reg_dst: RD_RT, mem_to_reg: M2R_ALU,
            is_beq: 1'b0, is_lw: 1'b0, is_sw: 1'b0, is_wb: 1'b0};
    case (op)
      OP_ADD: begin
        dec.reg_dst = RD_RD;
        dec.is_wb   = 1'b1;
      end
      OP_SLI: begin
        dec.alu_op       = 2'b10;
        dec.alu_src      = 1'b1;
        dec.sign_or_zero = 1'b0;
        dec.is_wb        = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op  = 2'b11;
        dec.alu_src = 1'b1;
        dec.is_wb   = 1'b1;
      end
      OP_LW: begin
        dec.alu_op     = 2'b11;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = M2R_MEM;
        dec.is_lw      = 1'b1;
      end
      OP_SW: begin
        dec.alu_op  = 2'b11;
        dec.alu_src = 1'b1;
        dec.is_sw   = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = 2'b01;
        dec.is_beq = 1'b1;
      end
      default: begin
        dec.is_wb = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath: sequences
// FETCH/DECODE/EXEC/MEM/WB, times out stalled memory and traps bad opcodes.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  mc_control_if.master bus
);

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [2:0]        op_q_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              illegal_r;
  logic              bus_err_r;
  logic              set_illegal_s;
  logic              set_bus_err_s;
  logic              illegal_op_s;
  logic              mem_phase_s;
  logic              timeout_s;
  ctrl_t             ctrl_s;
  ctrl_t             ctrl_out_s;
  dec_t              dec_s;

  mc_decode u_decode (
    .op  (op_q_r),
    .dec (dec_s)
  );

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign illegal_op_s = |bus.opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign illegal_op_s = 1'b0;
    end
  endgenerate

  assign mem_phase_s = (state_r == S_FETCH) || (state_r == S_MEM);
  // A ready on the last allowed cycle still wins over the timeout
  assign timeout_s   = mem_phase_s && !bus.mem_ready && (cnt_r == CNT_LAST);

  // Next-state and control-vector decode
  always_comb begin
    ctrl_s        = CTRL_DEFAULT;
    state_nxt_s   = state_r;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_read = 1'b1;
        if (timeout_s) begin
          set_bus_err_s = 1'b1;
          state_nxt_s   = S_HALT;
        end else if (bus.mem_ready) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = PC_INC;
          state_nxt_s     = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (illegal_op_s) begin
          set_illegal_s = 1'b1;
          state_nxt_s   = S_HALT;
        end else if (bus.opcode[2:0] == OP_J) begin
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = PC_JUMP;
          state_nxt_s     = S_FETCH;
        end else if (bus.opcode[2:0] == OP_JAL) begin
          ctrl_s.pc_write   = 1'b1;
          ctrl_s.pc_src     = PC_JUMP;
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = RD_RA;
          ctrl_s.mem_to_reg = M2R_PC;
          state_nxt_s       = S_FETCH;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        ctrl_s.alu_op       = dec_s.alu_op;
        ctrl_s.alu_src      = dec_s.alu_src;
        ctrl_s.sign_or_zero = dec_s.sign_or_zero;
        if (dec_s.is_beq) begin
          ctrl_s.pc_src   = PC_BRANCH;
          ctrl_s.pc_write = bus.zero;
          state_nxt_s     = S_FETCH;
        end else if (dec_s.is_lw || dec_s.is_sw) begin
          state_nxt_s = S_MEM;
        end else if (dec_s.is_wb) begin
          state_nxt_s = S_WB;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_MEM: begin
        ctrl_s.iord         = 1'b1;
        ctrl_s.alu_op       = dec_s.alu_op;
        ctrl_s.alu_src      = dec_s.alu_src;
        ctrl_s.sign_or_zero = dec_s.sign_or_zero;
        ctrl_s.mem_read     = dec_s.is_lw;
        ctrl_s.mem_write    = dec_s.is_sw;
        if (timeout_s) begin
          set_bus_err_s = 1'b1;
          state_nxt_s   = S_HALT;
        end else if (bus.mem_ready) begin
          state_nxt_s = dec_s.is_lw ? S_WB : S_FETCH;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        ctrl_s.alu_op       = dec_s.alu_op;
        ctrl_s.alu_src      = dec_s.alu_src;
        ctrl_s.sign_or_zero = dec_s.sign_or_zero;
        ctrl_s.reg_write    = 1'b1;
        ctrl_s.reg_dst      = dec_s.reg_dst;
        ctrl_s.mem_to_reg   = dec_s.mem_to_reg;
        state_nxt_s         = S_FETCH;
      end
      S_HALT: begin
        state_nxt_s = S_HALT;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Reset overrides outputs combinationally so strobes drop in the same cycle
  assign ctrl_out_s = reset ? CTRL_DEFAULT : ctrl_s;

  // State, latched opcode, wait counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      op_q_r    <= 3'b000;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) begin
        op_q_r <= bus.opcode[2:0];
      end
      if ((state_nxt_s != state_r) || bus.mem_ready) begin
        cnt_r <= '0;
      end else if (mem_phase_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
    end
  end

  assign bus.ir_write     = ctrl_out_s.ir_write;
  assign bus.pc_write     = ctrl_out_s.pc_write;
  assign bus.iord         = ctrl_out_s.iord;
  assign bus.pc_src       = ctrl_out_s.pc_src;
  assign bus.reg_dst      = ctrl_out_s.reg_dst;
  assign bus.mem_to_reg   = ctrl_out_s.mem_to_reg;
  assign bus.alu_op       = ctrl_out_s.alu_op;
  assign bus.alu_src      = ctrl_out_s.alu_src;
  assign bus.mem_read     = ctrl_out_s.mem_read;
  assign bus.mem_write    = ctrl_out_s.mem_write;
  assign bus.reg_write    = ctrl_out_s.reg_write;
  assign bus.sign_or_zero = ctrl_out_s.sign_or_zero;
  assign bus.illegal      = reset ? 1'b0 : illegal_r;
  assign bus.bus_err      = reset ? 1'b0 : bus_err_r;
  assign bus.state        = state_r;

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control: dut0 uses default parameters,
// dut1 uses a 4-bit opcode and a short timeout. One DUT runs while the other sits in reset.
module tb_mc_control;

  // Control vector order:
  // {ir_write, pc_write, iord, pc_src, reg_dst, mem_to_reg, alu_op, alu_src,
  //  mem_read, mem_write, reg_write, sign_or_zero}
  localparam logic [15:0] DFLT     = 16'b0_0_0_00_00_00_00_0_0_0_0_1;
  localparam logic [15:0] F_RDY    = 16'b1_1_0_00_00_00_00_0_1_0_0_1;
  localparam logic [15:0] F_WAIT   = 16'b0_0_0_00_00_00_00_0_1_0_0_1;
  localparam logic [15:0] ADD_WB   = 16'b0_0_0_00_01_00_00_0_0_0_1_1;
  localparam logic [15:0] LS_EXEC  = 16'b0_0_0_00_00_00_11_1_0_0_0_1;
  localparam logic [15:0] LW_MEM   = 16'b0_0_1_00_00_00_11_1_1_0_0_1;
  localparam logic [15:0] SW_MEM   = 16'b0_0_1_00_00_00_11_1_0_1_0_1;
  localparam logic [15:0] LW_WB    = 16'b0_0_0_00_00_01_11_1_0_0_1_1;
  localparam logic [15:0] ADDI_WB  = 16'b0_0_0_00_00_00_11_1_0_0_1_1;
  localparam logic [15:0] SLI_EXEC = 16'b0_0_0_00_00_00_10_1_0_0_0_0;
  localparam logic [15:0] SLI_WB   = 16'b0_0_0_00_00_00_10_1_0_0_1_0;
  localparam logic [15:0] BEQ_NT   = 16'b0_0_0_01_00_00_01_0_0_0_0_1;
  localparam logic [15:0] BEQ_T    = 16'b0_1_0_01_00_00_01_0_0_0_0_1;
  localparam logic [15:0] J_DEC    = 16'b0_1_0_10_00_00_00_0_0_0_0_1;
  localparam logic [15:0] JAL_DEC  = 16'b0_1_0_10_10_10_00_0_0_0_1_1;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] cv;
    logic        ill;
    logic        be;
    logic        chk_st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0;
  logic       rst1;
  logic [3:0] op_v;
  logic       zero_v;
  logic       ready_v;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  mc_control_if #(.OPCODE_W(3)) bus0 ();
  mc_control_if #(.OPCODE_W(4)) bus1 ();

  assign bus0.opcode    = op_v[2:0];
  assign bus0.zero      = zero_v;
  assign bus0.mem_ready = ready_v;
  assign bus1.opcode    = op_v;
  assign bus1.zero      = zero_v;
  assign bus1.mem_ready = ready_v;

  mc_control #(.OPCODE_W(3), .TIMEOUT(16)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  mc_control #(.OPCODE_W(4), .TIMEOUT(4))  dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  wire [15:0] cv0 = {bus0.ir_write, bus0.pc_write, bus0.iord, bus0.pc_src, bus0.reg_dst,
                     bus0.mem_to_reg, bus0.alu_op, bus0.alu_src, bus0.mem_read,
                     bus0.mem_write, bus0.reg_write, bus0.sign_or_zero};
  wire [15:0] cv1 = {bus1.ir_write, bus1.pc_write, bus1.iord, bus1.pc_src, bus1.reg_dst,
                     bus1.mem_to_reg, bus1.alu_op, bus1.alu_src, bus1.mem_read,
                     bus1.mem_write, bus1.reg_write, bus1.sign_or_zero};

  // One clock cycle: drive inputs, queue the expectation, check at negedge
  task automatic step(input string tag, input bit sel, input logic rst,
                      input logic rdy, input logic z, input logic [3:0] op,
                      input logic [2:0] est, input logic [15:0] ecv,
                      input logic eill, input logic ebe);
    exp_t        e;
    string       t;
    logic [15:0] o_cv;
    logic [2:0]  o_st;
    logic        o_ill;
    logic        o_be;
    if (sel) rst1 = rst; else rst0 = rst;
    ready_v = rdy;
    zero_v  = z;
    op_v    = op;
    exp_q.push_back('{est, ecv, eill, ebe, !rst});
    tag_q.push_back(tag);
    @(negedge clk);
    e     = exp_q.pop_front();
    t     = tag_q.pop_front();
    o_cv  = sel ? cv1 : cv0;
    o_st  = sel ? bus1.state : bus0.state;
    o_ill = sel ? bus1.illegal : bus0.illegal;
    o_be  = sel ? bus1.bus_err : bus0.bus_err;
    checks++;
    assert (o_cv === e.cv) else begin
      errors++;
      $error("FAIL %s ctrl: observed %b expected %b", t, o_cv, e.cv);
    end
    if (e.chk_st) begin
      checks++;
      assert (o_st === e.st) else begin
        errors++;
        $error("FAIL %s state: observed %0d expected %0d", t, o_st, e.st);
      end
      checks++;
      assert (o_ill === e.ill) else begin
        errors++;
        $error("FAIL %s illegal: observed %b expected %b", t, o_ill, e.ill);
      end
      checks++;
      assert (o_be === e.be) else begin
        errors++;
        $error("FAIL %s bus_err: observed %b expected %b", t, o_be, e.be);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; op_v = 4'd0; zero_v = 1'b0; ready_v = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // dut0: reset, then add
    step("rst0",        1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, DFLT,   1'b0, 1'b0);
    step("add_fetch",   1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, F_RDY,  1'b0, 1'b0);
    step("add_dec",     1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd1, DFLT,   1'b0, 1'b0);
    step("add_exec",    1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd2, DFLT,   1'b0, 1'b0);
    step("add_wb",      1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd4, ADD_WB, 1'b0, 1'b0);
    // lw with three MEM wait cycles; mem_ready low in DECODE/EXEC is ignored
    step("lw_fetch",    1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 3'd0, F_RDY,   1'b0, 1'b0);
    step("lw_dec",      1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 3'd1, DFLT,    1'b0, 1'b0);
    step("lw_exec",     1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 3'd2, LS_EXEC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 3'd3, LW_MEM, 1'b0, 1'b0);
    step("lw_mem_done", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 3'd3, LW_MEM,  1'b0, 1'b0);
    step("lw_wb",       1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 3'd4, LW_WB,   1'b0, 1'b0);
    // beq not taken, then taken
    step("beq0_fetch",  1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 3'd0, F_RDY,  1'b0, 1'b0);
    step("beq0_dec",    1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 3'd1, DFLT,   1'b0, 1'b0);
    step("beq0_exec",   1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 3'd2, BEQ_NT, 1'b0, 1'b0);
    step("beq1_fetch",  1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 3'd0, F_RDY,  1'b0, 1'b0);
    step("beq1_dec",    1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 3'd1, DFLT,   1'b0, 1'b0);
    step("beq1_exec",   1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 3'd2, BEQ_T,  1'b0, 1'b0);
    // j and jal
    step("j_fetch",     1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 3'd0, F_RDY,   1'b0, 1'b0);
    step("j_dec",       1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 3'd1, J_DEC,   1'b0, 1'b0);
    step("jal_fetch",   1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 3'd0, F_RDY,   1'b0, 1'b0);
    step("jal_dec",     1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 3'd1, JAL_DEC, 1'b0, 1'b0);
    // sli and addi
    step("sli_fetch",   1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0, F_RDY,    1'b0, 1'b0);
    step("sli_dec",     1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd1, DFLT,     1'b0, 1'b0);
    step("sli_exec",    1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd2, SLI_EXEC, 1'b0, 1'b0);
    step("sli_wb",      1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd4, SLI_WB,   1'b0, 1'b0);
    step("addi_fetch",  1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 3'd0, F_RDY,    1'b0, 1'b0);
    step("addi_dec",    1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 3'd1, DFLT,     1'b0, 1'b0);
    step("addi_exec",   1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 3'd2, LS_EXEC,  1'b0, 1'b0);
    step("addi_wb",     1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 3'd4, ADDI_WB,  1'b0, 1'b0);
    // sw completing normally
    step("sw_fetch",    1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd0, F_RDY,   1'b0, 1'b0);
    step("sw_dec",      1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd1, DFLT,    1'b0, 1'b0);
    step("sw_exec",     1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd2, LS_EXEC, 1'b0, 1'b0);
    step("sw_mem",      1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd3, SW_MEM,  1'b0, 1'b0);
    // sw interrupted by reset while mem_write is high
    step("swr_fetch",   1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd0, F_RDY,   1'b0, 1'b0);
    step("swr_dec",     1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd1, DFLT,    1'b0, 1'b0);
    step("swr_exec",    1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd2, LS_EXEC, 1'b0, 1'b0);
    step("swr_mem",     1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 3'd3, SW_MEM,  1'b0, 1'b0);
    step("swr_reset",   1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 3'd3, DFLT,    1'b0, 1'b0);
    step("swr_refetch", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd0, F_RDY,   1'b0, 1'b0);
    rst0 = 1'b1;

    // dut1: illegal opcode trap
    step("rst1",        1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 3'd0, DFLT,  1'b0, 1'b0);
    step("ill_fetch",   1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 3'd0, F_RDY, 1'b0, 1'b0);
    step("ill_dec",     1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 3'd1, DFLT,  1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("ill_halt",  1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 3'd7, DFLT,  1'b1, 1'b0);
    step("ill_reset",   1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 3'd7, DFLT,  1'b0, 1'b0);
    // timeout in FETCH: four cycles of mem_ready low
    for (int i = 0; i < 4; i++)
      step("to_wait",   1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, F_WAIT, 1'b0, 1'b0);
    step("to_halt",     1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd7, DFLT,   1'b0, 1'b1);
    step("to_halt2",    1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd7, DFLT,   1'b0, 1'b1);
    step("to_reset",    1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd7, DFLT,   1'b0, 1'b0);
    // mem_ready arrives on the last allowed cycle
    for (int i = 0; i < 3; i++)
      step("late_wait", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, F_WAIT, 1'b0, 1'b0);
    step("late_ready",  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, F_RDY,  1'b0, 1'b0);
    step("late_dec",    1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd1, DFLT,   1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
